// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, including the
// EBREAK/FENCE drain-and-halt sequence and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d_valid,
    input  logic                   d_pause,
    input  logic [4:0]             d_rs1,
    input  logic [4:0]             d_rs2,
    input  logic                   d_uses_rs1,
    input  logic                   d_uses_rs2,
    input  logic                   e_valid,
    input  logic                   e_writesreg,
    input  logic                   e_memtoreg,
    input  logic                   e_redirect,
    input  logic [4:0]             e_rd,
    input  logic [4:0]             e_rs1,
    input  logic [4:0]             e_rs2,
    input  logic                   m_valid,
    input  logic                   m_writesreg,
    input  logic                   m_memreq,
    input  logic [4:0]             m_rd,
    input  logic                   w_valid,
    input  logic                   w_writesreg,
    input  logic [4:0]             w_rd,
    input  logic                   dmem_ready,
    input  logic                   resume,
    output logic                   stall_fd,
    output logic                   stall_em,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic                   flush_w,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t state;
    logic   mem_stall, load_use, pipe_empty;
    logic   stall_fd_c, stall_em_c, flush_d_c, flush_e_c, flush_w_c, halted_c;
    logic   enter_drain;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign mem_stall  = m_valid & m_memreq & ~dmem_ready;
    assign load_use   = e_valid & e_memtoreg & (e_rd != 5'd0) & d_valid &
                        ((d_uses_rs1 & (d_rs1 == e_rd)) | (d_uses_rs2 & (d_rs2 == e_rd)));
    assign pipe_empty = ~e_valid & ~m_valid & ~w_valid & ~mem_stall;

    // A frozen E stage defers redirect, load-use and pause until memory completes.
    always_comb begin
        stall_fd_c  = 1'b0;
        stall_em_c  = 1'b0;
        flush_d_c   = 1'b0;
        flush_e_c   = 1'b0;
        flush_w_c   = 1'b0;
        halted_c    = 1'b0;
        enter_drain = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    stall_fd_c = 1'b1;
                    stall_em_c = 1'b1;
                    flush_w_c  = 1'b1;
                end else if (e_valid && e_redirect) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (load_use) begin
                    stall_fd_c = 1'b1;
                    flush_e_c  = 1'b1;
                end else if (d_valid && d_pause) begin
                    stall_fd_c  = 1'b1;
                    flush_e_c   = 1'b1;
                    enter_drain = 1'b1;
                end
            end
            DRAIN: begin
                stall_fd_c = 1'b1;
                flush_e_c  = 1'b1;
                stall_em_c = mem_stall;
                flush_w_c  = mem_stall;
            end
            HALTED: begin
                flush_e_c = 1'b1;
                if (resume) begin
                    flush_d_c = 1'b1;
                end else begin
                    stall_fd_c = 1'b1;
                    halted_c   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (m_valid && m_writesreg && m_rd != 5'd0 && m_rd == e_rs1)
            fwd_a_c = 2'b01;
        else if (w_valid && w_writesreg && w_rd != 5'd0 && w_rd == e_rs1)
            fwd_a_c = 2'b10;
        if (m_valid && m_writesreg && m_rd != 5'd0 && m_rd == e_rs2)
            fwd_b_c = 2'b01;
        else if (w_valid && w_writesreg && w_rd != 5'd0 && w_rd == e_rs2)
            fwd_b_c = 2'b10;
    end

    // Every output is held low while reset is asserted, independent of inputs.
    assign stall_fd = rst_n & stall_fd_c;
    assign stall_em = rst_n & stall_em_c;
    assign flush_d  = rst_n & flush_d_c;
    assign flush_e  = rst_n & flush_e_c;
    assign flush_w  = rst_n & flush_w_c;
    assign halted   = rst_n & halted_c;
    assign fwd_a    = rst_n ? fwd_a_c : 2'b00;
    assign fwd_b    = rst_n ? fwd_b_c : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            stall_cycles <= '0;
        end else begin
            unique case (state)
                RUN:     if (enter_drain) state <= DRAIN;
                DRAIN:   if (pipe_empty)  state <= HALTED;
                HALTED:  if (resume)      state <= RUN;
                default: state <= RUN;
            endcase
            if (stall_fd_c && state != HALTED && !(&stall_cycles))
                stall_cycles <= stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_valid, d_pause, d_uses_rs1, d_uses_rs2;
    logic [4:0] d_rs1, d_rs2;
    logic e_valid, e_writesreg, e_memtoreg, e_redirect;
    logic [4:0] e_rd, e_rs1, e_rs2;
    logic m_valid, m_writesreg, m_memreq;
    logic [4:0] m_rd;
    logic w_valid, w_writesreg;
    logic [4:0] w_rd;
    logic dmem_ready, resume;
    logic stall_fd, stall_em, flush_d, flush_e, flush_w, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles;

    int n_vec = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_pause(d_pause), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
        .e_valid(e_valid), .e_writesreg(e_writesreg), .e_memtoreg(e_memtoreg),
        .e_redirect(e_redirect), .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .m_valid(m_valid), .m_writesreg(m_writesreg), .m_memreq(m_memreq), .m_rd(m_rd),
        .w_valid(w_valid), .w_writesreg(w_writesreg), .w_rd(w_rd),
        .dmem_ready(dmem_ready), .resume(resume),
        .stall_fd(stall_fd), .stall_em(stall_em), .flush_d(flush_d), .flush_e(flush_e),
        .flush_w(flush_w), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = running, 1 = draining, 2 = halted.
    int mode = 0, mode_nx = 0;
    int mcnt = 0, mcnt_nx = 0;
    int x_sfd, x_sem, x_fd, x_fe, x_fw, x_h, x_fa, x_fb;

    function automatic int fwd_src(input logic [4:0] rs);
        if (m_valid && m_writesreg && m_rd != 0 && m_rd == rs) return 1;
        if (w_valid && w_writesreg && w_rd != 0 && w_rd == rs) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit ms, lu;
        x_sfd = 0; x_sem = 0; x_fd = 0; x_fe = 0; x_fw = 0; x_h = 0; x_fa = 0; x_fb = 0;
        if (!rst_n) begin
            mode = 0; mcnt = 0; mode_nx = 0; mcnt_nx = 0;
        end else begin
            mode_nx = mode;
            ms = m_valid && m_memreq && !dmem_ready;
            lu = e_valid && e_memtoreg && e_rd != 0 && d_valid &&
                 ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd));
            if (mode == 0) begin
                if (ms) begin x_sfd = 1; x_sem = 1; x_fw = 1; end
                else if (e_valid && e_redirect) begin x_fd = 1; x_fe = 1; end
                else if (lu) begin x_sfd = 1; x_fe = 1; end
                else if (d_valid && d_pause) begin x_sfd = 1; x_fe = 1; mode_nx = 1; end
            end else if (mode == 1) begin
                x_sfd = 1; x_fe = 1;
                if (ms) begin x_sem = 1; x_fw = 1; end
                if (!e_valid && !m_valid && !w_valid && !ms) mode_nx = 2;
            end else begin
                x_fe = 1;
                if (resume) begin x_fd = 1; mode_nx = 0; end
                else begin x_sfd = 1; x_h = 1; end
            end
            x_fa = fwd_src(e_rs1);
            x_fb = fwd_src(e_rs2);
            mcnt_nx = (x_sfd == 1 && mode != 2) ? ((mcnt + 1 > CNTMAX) ? CNTMAX : mcnt + 1) : mcnt;
        end
        check_output("stall_fd", int'(stall_fd), x_sfd);
        check_output("stall_em", int'(stall_em), x_sem);
        check_output("flush_d", int'(flush_d), x_fd);
        check_output("flush_e", int'(flush_e), x_fe);
        check_output("flush_w", int'(flush_w), x_fw);
        check_output("halted", int'(halted), x_h);
        check_output("fwd_a", int'(fwd_a), x_fa);
        check_output("fwd_b", int'(fwd_b), x_fb);
        check_output("stall_cycles", int'(stall_cycles), mcnt);
    end

    always @(posedge clk) begin
        mode = mode_nx;
        mcnt = mcnt_nx;
    end

    task automatic set_idle();
        d_valid = 0; d_pause = 0; d_rs1 = 0; d_rs2 = 0; d_uses_rs1 = 0; d_uses_rs2 = 0;
        e_valid = 0; e_writesreg = 0; e_memtoreg = 0; e_redirect = 0;
        e_rd = 0; e_rs1 = 0; e_rs2 = 0;
        m_valid = 0; m_writesreg = 0; m_memreq = 0; m_rd = 0;
        w_valid = 0; w_writesreg = 0; w_rd = 0;
        dmem_ready = 1; resume = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle(); rst_n = 0; set_idle();
        next_cycle(); rst_n = 1;
    endtask

    task automatic set_load_use();
        set_idle();
        e_valid = 1; e_writesreg = 1; e_memtoreg = 1; e_rd = 5;
        d_valid = 1; d_rs1 = 5; d_uses_rs1 = 1;
    endtask

    task automatic apply_stimulus();
        d_valid     = ($urandom_range(0, 2) == 0);
        d_pause     = ($urandom_range(0, 7) == 0);
        d_rs1       = 5'($urandom_range(0, 3));
        d_rs2       = 5'($urandom_range(0, 3));
        d_uses_rs1  = 1'($urandom_range(0, 1));
        d_uses_rs2  = 1'($urandom_range(0, 1));
        e_valid     = ($urandom_range(0, 2) == 0);
        e_writesreg = 1'($urandom_range(0, 1));
        e_memtoreg  = 1'($urandom_range(0, 1));
        e_redirect  = ($urandom_range(0, 3) == 0);
        e_rd        = 5'($urandom_range(0, 3));
        e_rs1       = 5'($urandom_range(0, 3));
        e_rs2       = 5'($urandom_range(0, 3));
        m_valid     = ($urandom_range(0, 2) == 0);
        m_writesreg = 1'($urandom_range(0, 1));
        m_memreq    = 1'($urandom_range(0, 1));
        m_rd        = 5'($urandom_range(0, 3));
        w_valid     = ($urandom_range(0, 2) == 0);
        w_writesreg = 1'($urandom_range(0, 1));
        w_rd        = 5'($urandom_range(0, 3));
        dmem_ready  = ($urandom_range(0, 3) != 0);
        resume      = ($urandom_range(0, 3) == 0);
        rst_n       = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        set_idle();
        d_valid = 1; d_pause = 1; e_valid = 1; e_redirect = 1;
        m_valid = 1; m_memreq = 1; dmem_ready = 0;
        @(negedge clk);
        check_output("rst_stall_fd", int'(stall_fd), 0);
        check_output("rst_stall_em", int'(stall_em), 0);
        check_output("rst_cnt", int'(stall_cycles), 0);
        next_cycle(); rst_n = 1; set_idle();

        // Load-use hazard, then the dependent op in E forwarding from M.
        next_cycle(); set_load_use();
        @(negedge clk);
        check_output("lu_stall_fd", int'(stall_fd), 1);
        check_output("lu_flush_e", int'(flush_e), 1);
        check_output("lu_flush_d", int'(flush_d), 0);
        next_cycle(); set_idle();
        m_valid = 1; m_writesreg = 1; m_rd = 5; e_valid = 1; e_rs1 = 5;
        @(negedge clk);
        check_output("lu_after_stall", int'(stall_fd), 0);
        check_output("lu_after_fwd_a", int'(fwd_a), 1);
        next_cycle(); set_load_use(); e_rd = 0; d_rs1 = 0;
        @(negedge clk);
        check_output("lu_x0_stall", int'(stall_fd), 0);

        // Redirect kills a pause sitting in D.
        next_cycle(); set_idle(); e_valid = 1; e_redirect = 1; d_valid = 1; d_pause = 1;
        @(negedge clk);
        check_output("rp_flush_d", int'(flush_d), 1);
        check_output("rp_flush_e", int'(flush_e), 1);
        check_output("rp_stall_fd", int'(stall_fd), 0);
        next_cycle(); set_idle();
        @(negedge clk);
        check_output("rp_still_run", int'(stall_fd), 0);
        check_output("rp_halted", int'(halted), 0);

        // Pause drain: pause at cycle 10, halted from 13, resume at 20.
        do_reset();
        next_cycle(); set_idle();
        d_valid = 1; d_pause = 1; e_valid = 1; m_valid = 1; w_valid = 1;
        @(negedge clk);
        check_output("pd10_stall_fd", int'(stall_fd), 1);
        check_output("pd10_flush_e", int'(flush_e), 1);
        next_cycle(); e_valid = 0;
        @(negedge clk);
        check_output("pd11_halted", int'(halted), 0);
        check_output("pd11_stall_fd", int'(stall_fd), 1);
        next_cycle(); m_valid = 0; w_valid = 0; resume = 1;
        @(negedge clk);
        check_output("pd12_halted", int'(halted), 0);
        for (int c = 13; c < 20; c++) begin
            next_cycle(); resume = 0;
            @(negedge clk);
            check_output("pd_halted", int'(halted), 1);
        end
        next_cycle(); resume = 1;
        @(negedge clk);
        check_output("pd20_flush_d", int'(flush_d), 1);
        check_output("pd20_stall_fd", int'(stall_fd), 0);
        check_output("pd20_halted", int'(halted), 0);
        next_cycle(); set_idle(); d_valid = 1;
        @(negedge clk);
        check_output("pd21_stall_fd", int'(stall_fd), 0);
        check_output("pd21_cnt", int'(stall_cycles), 3);

        // Memory wait overlapping a redirect.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            next_cycle(); set_idle();
            m_valid = 1; m_memreq = 1; dmem_ready = 0; e_valid = 1; e_redirect = 1;
            @(negedge clk);
            check_output("mw_stall_em", int'(stall_em), 1);
            check_output("mw_flush_w", int'(flush_w), 1);
            check_output("mw_flush_d", int'(flush_d), 0);
        end
        next_cycle(); dmem_ready = 1;
        @(negedge clk);
        check_output("mw5_flush_d", int'(flush_d), 1);
        check_output("mw5_flush_e", int'(flush_e), 1);
        check_output("mw5_stall_em", int'(stall_em), 0);

        // Forwarding priority.
        next_cycle(); set_idle(); e_valid = 1; e_rs1 = 7; e_rs2 = 7;
        m_valid = 1; m_writesreg = 1; m_rd = 7; w_valid = 1; w_writesreg = 1; w_rd = 7;
        @(negedge clk);
        check_output("fw_mw_a", int'(fwd_a), 1);
        check_output("fw_mw_b", int'(fwd_b), 1);
        next_cycle(); m_valid = 0;
        @(negedge clk);
        check_output("fw_w_a", int'(fwd_a), 2);
        check_output("fw_w_b", int'(fwd_b), 2);
        next_cycle(); w_rd = 0;
        @(negedge clk);
        check_output("fw_x0_a", int'(fwd_a), 0);

        // Counter saturation, then reset in the middle of counting.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            next_cycle(); set_load_use();
        end
        next_cycle(); set_idle();
        @(negedge clk);
        check_output("sat_cnt", int'(stall_cycles), 15);
        for (int c = 0; c < 5; c++) begin
            next_cycle(); set_load_use();
        end
        next_cycle(); rst_n = 0;
        @(negedge clk);
        check_output("midrst_cnt", int'(stall_cycles), 0);
        check_output("midrst_stall_fd", int'(stall_fd), 0);
        check_output("midrst_flush_e", int'(flush_e), 0);

        // Reset while draining returns to a clean RUN.
        next_cycle(); rst_n = 1; set_idle(); d_valid = 1; d_pause = 1;
        next_cycle(); set_idle(); m_valid = 1;
        next_cycle(); rst_n = 0;
        next_cycle(); rst_n = 1; set_idle();
        @(negedge clk);
        check_output("drrst_stall_fd", int'(stall_fd), 0);
        check_output("drrst_flush_e", int'(flush_e), 0);
        check_output("drrst_halted", int'(halted), 0);

        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            apply_stimulus();
        end
        next_cycle(); rst_n = 1; set_idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
